// File: rtl/condlogic_pred.sv
// condlogic_pred: conditional-execution unit for the multicycle ARM core, with
// independently writable flag groups and an IT-style predicated-block sequencer.
//
// A header instruction (PredStart at InstrDone) opens a block of up to BLKDEPTH
// instructions. Each block member runs on the header condition (mask bit 1) or on
// its inverse (mask bit 0). The header itself runs on its own Cond.
//
// Parameters:
//   NGRP      number of flag write groups (1, 2 or 4); each group is 4/NGRP bits
//   BLKDEPTH  maximum predicated block length (2..8)
//   CNTW      derived block-counter width, not overridable
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   Cond, ALUFlags      condition field of current instruction, ALU {N,Z,C,V}
//   FlagW               per-group flag write request
//   PCS, NextPC         instruction writes PC, FSM unconditional PC update
//   RegW, MemW          register / memory write requests
//   InstrDone           pulse in the last state of each instruction
//   PredStart           current instruction is a block header
//   PredMask, PredLen   per-member condition select, block length (1..BLKDEPTH)
//   PCWrite, RegWrite, MemWrite  qualified write enables
//   Flags               architectural flags
//   PredActive          block in progress
//   PredErr             sticky illegal/nested header indicator
//
// Build option: define CONDLOGIC_PREDERR_EN to enable PredErr; otherwise PredErr
// is tied low and bad headers are silently ignored.
module condlogic_pred #(
  parameter int unsigned NGRP     = 2,
  parameter int unsigned BLKDEPTH = 4,
  localparam int unsigned CNTW    = $clog2(BLKDEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [NGRP-1:0]     FlagW,
  input  logic                PCS,
  input  logic                NextPC,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                InstrDone,
  input  logic                PredStart,
  input  logic [BLKDEPTH-1:0] PredMask,
  input  logic [CNTW-1:0]     PredLen,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [3:0]          Flags,
  output logic                PredActive,
  output logic                PredErr
);

  localparam int unsigned GW = 4 / NGRP;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q, state_d;
  logic [3:0]          pred_cond_q, pred_cond_d;
  logic [BLKDEPTH-1:0] mask_q, mask_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [3:0]          flags_q;
  logic                next_cond_ex_q;
  logic [3:0]          eff_cond;
  logic                cond_ex;
  logic [NGRP-1:0]     flag_write;
  logic                len_ok;

  assign len_ok = (PredLen >= CNTW'(1)) && (PredLen <= CNTW'(BLKDEPTH));

  // Inside a block, bit 0 of the header condition is flipped for inverse members;
  // AL is never inverted so an AL block always executes.
  always_comb begin
    eff_cond = Cond;
    if (state_q == StActive) begin
      eff_cond = pred_cond_q;
      if (pred_cond_q != 4'b1110) begin
        eff_cond[0] = pred_cond_q[0] ^ ~mask_q[0];
      end
    end
  end

  // Flags are {N,Z,C,V}.
  always_comb begin
    cond_ex = 1'b0;
    unique case (eff_cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      default: cond_ex = 1'b1;
    endcase
  end

  assign flag_write = FlagW & {NGRP{cond_ex}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      for (int unsigned g = 0; g < NGRP; g++) begin
        if (flag_write[g]) begin
          flags_q[g*GW +: GW] <= ALUFlags[g*GW +: GW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_cond_ex_q <= 1'b0;
    end else begin
      next_cond_ex_q <= cond_ex;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_cond_d = pred_cond_q;
    mask_d      = mask_q;
    count_d     = count_q;
    unique case (state_q)
      StIdle: begin
        if (InstrDone && PredStart && len_ok) begin
          state_d     = StActive;
          pred_cond_d = Cond;
          mask_d      = PredMask;
          count_d     = PredLen;
        end
      end
      StActive: begin
        if (InstrDone) begin
          // A taken branch inside the block ends it early.
          if (PCS && next_cond_ex_q) begin
            state_d = StIdle;
            count_d = '0;
            mask_d  = '0;
          end else begin
            mask_d  = mask_q >> 1;
            count_d = count_q - CNTW'(1);
            if (count_q == CNTW'(1)) begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pred_cond_q <= '0;
      mask_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pred_cond_q <= pred_cond_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
    end
  end

`ifdef CONDLOGIC_PREDERR_EN
  logic pred_err_q;
  logic hdr_bad;

  // Bad header: illegal length in IDLE, or any header inside a block.
  assign hdr_bad = InstrDone & PredStart & ((state_q == StActive) | ~len_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_err_q <= 1'b0;
    end else if (hdr_bad) begin
      pred_err_q <= 1'b1;
    end
  end

  assign PredErr = pred_err_q;
`else
  assign PredErr = 1'b0;
`endif

  assign PCWrite    = (PCS & next_cond_ex_q) | NextPC;
  assign RegWrite   = RegW & next_cond_ex_q;
  assign MemWrite   = MemW & next_cond_ex_q;
  assign Flags      = flags_q;
  assign PredActive = (state_q == StActive);

endmodule

// File: tb/tb_condlogic_pred.sv
module tb_condlogic_pred;

  localparam int unsigned NGRP     = 2;
  localparam int unsigned BLKDEPTH = 4;
  localparam int unsigned CNTW     = $clog2(BLKDEPTH + 1);
  localparam int unsigned GW       = 4 / NGRP;
`ifdef CONDLOGIC_PREDERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          Cond;
  logic [3:0]          ALUFlags;
  logic [NGRP-1:0]     FlagW;
  logic                PCS, NextPC, RegW, MemW, InstrDone, PredStart;
  logic [BLKDEPTH-1:0] PredMask;
  logic [CNTW-1:0]     PredLen;
  logic                PCWrite, RegWrite, MemWrite, PredActive, PredErr;
  logic [3:0]          Flags;

  int checks = 0;
  int errors = 0;

  condlogic_pred #(
    .NGRP     (NGRP),
    .BLKDEPTH (BLKDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .InstrDone  (InstrDone),
    .PredStart  (PredStart),
    .PredMask   (PredMask),
    .PredLen    (PredLen),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Flags      (Flags),
    .PredActive (PredActive),
    .PredErr    (PredErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition: bits [3:1] select a test, bit 0 inverts it; 111x is always.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // Reference model state.
  logic [3:0] m_flags  = '0;
  bit         m_nce    = 1'b0;
  bit         m_active = 1'b0;
  bit         m_err    = 1'b0;
  logic [3:0] m_pc     = '0;
  int         m_left   = 0;
  bit         mq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags  = '0;
      m_nce    = 1'b0;
      m_active = 1'b0;
      m_err    = 1'b0;
      m_left   = 0;
      mq.delete();
    end else begin
      bit ce;
      bit use_hdr;
      logic [3:0] ec;
      ec = Cond;
      if (m_active) begin
        use_hdr = (mq.size() > 0) ? mq[0] : 1'b0;
        ec = m_pc;
        if (!use_hdr && m_pc != 4'b1110) ec[0] = ~ec[0];
      end
      ce = cond_true(ec, m_flags);
      for (int g = 0; g < NGRP; g++) begin
        if (FlagW[g] && ce) begin
          for (int b = 0; b < GW; b++) m_flags[g*GW+b] = ALUFlags[g*GW+b];
        end
      end
      if (InstrDone) begin
        if (!m_active) begin
          if (PredStart) begin
            if (PredLen >= 1 && PredLen <= BLKDEPTH) begin
              m_active = 1'b1;
              m_pc     = Cond;
              m_left   = int'(PredLen);
              mq.delete();
              for (int i = 0; i < BLKDEPTH; i++) mq.push_back(PredMask[i]);
            end else if (ERR_EN) begin
              m_err = 1'b1;
            end
          end
        end else begin
          if (PredStart && ERR_EN) m_err = 1'b1;
          if (PCS && m_nce) begin
            m_active = 1'b0;
            m_left   = 0;
            mq.delete();
          end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            m_left--;
            if (m_left == 0) m_active = 1'b0;
          end
        end
      end
      m_nce = ce;
    end
  end

  always @(negedge clk) begin
    check("PCWrite",    8'(PCWrite),    8'((PCS && m_nce) || NextPC));
    check("RegWrite",   8'(RegWrite),   8'(RegW && m_nce));
    check("MemWrite",   8'(MemWrite),   8'(MemW && m_nce));
    check("Flags",      8'(Flags),      8'(m_flags));
    check("PredActive", 8'(PredActive), 8'(m_active));
    check("PredErr",    8'(PredErr),    8'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    Cond = 4'b1110; ALUFlags = '0; FlagW = '0; PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
    InstrDone = 0; PredStart = 0; PredMask = '0; PredLen = '0;
  endtask

  initial begin
    clear_in();
    reset  = 1'b0;
    NextPC = 1'b1;

    // Model pins.
    check("model_eq",  8'(cond_true(4'b0000, 4'b0100)), 8'd1);
    check("model_ne",  8'(cond_true(4'b0001, 4'b0100)), 8'd0);
    check("model_gt",  8'(cond_true(4'b1100, 4'b1001)), 8'd1);
    check("model_lt",  8'(cond_true(4'b1011, 4'b1000)), 8'd1);
    check("model_hi",  8'(cond_true(4'b1000, 4'b0110)), 8'd0);

    #2;
    check("rst_pcwrite",  8'(PCWrite), 8'd1);
    check("rst_flags",    8'(Flags), 8'd0);
    check("rst_regwrite", 8'(RegWrite), 8'd0);
    check("rst_active",   8'(PredActive), 8'd0);
    step(); step();
    reset = 1'b1;
    NextPC = 1'b0;
    step();

    // Plain condition: set Z, then NE fails and EQ passes.
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    FlagW = '0; Cond = 4'b0001; RegW = 1;
    step();
    @(negedge clk) check("ne_regwrite", 8'(RegWrite), 8'd0);
    Cond = 4'b0000;
    step();
    @(negedge clk) check("eq_regwrite", 8'(RegWrite), 8'd1);

    // Block: EQ, mask 0101, length 3, two-cycle members.
    RegW = 0; Cond = 4'b0000; PredStart = 1; PredMask = 4'b0101; PredLen = 3'd3; InstrDone = 1;
    step();
    PredStart = 0; InstrDone = 0; Cond = 4'b1110; RegW = 1;
    step();
    @(negedge clk) check("blk0_regwrite", 8'(RegWrite), 8'd1);
    InstrDone = 1; step(); InstrDone = 0; step();
    @(negedge clk) check("blk1_regwrite", 8'(RegWrite), 8'd0);
    InstrDone = 1; step(); InstrDone = 0; step();
    @(negedge clk) begin
      check("blk2_regwrite", 8'(RegWrite), 8'd1);
      check("blk2_active", 8'(PredActive), 8'd1);
    end
    InstrDone = 1; step(); InstrDone = 0; RegW = 0;
    @(negedge clk) check("blk_end_active", 8'(PredActive), 8'd0);

    // Flag group 1 write with CondEx=1, then with CondEx=0.
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    step();
    @(negedge clk) check("grp_write", 8'(Flags), 8'b1100);
    Cond = 4'b0001; ALUFlags = 4'b0000;
    step();
    @(negedge clk) check("grp_nowrite", 8'(Flags), 8'b1100);
    FlagW = '0;

    // Abort on a taken branch in the second member.
    Cond = 4'b0000; PredStart = 1; PredMask = 4'b1111; PredLen = 3'd3; InstrDone = 1;
    step();
    PredStart = 0; InstrDone = 0; step(); InstrDone = 1; step();
    InstrDone = 0; PCS = 1; step();
    @(negedge clk) check("abort_pcwrite", 8'(PCWrite), 8'd1);
    InstrDone = 1; step();
    @(negedge clk) check("abort_idle", 8'(PredActive), 8'd0);
    PCS = 0; InstrDone = 0; Cond = 4'b0001; RegW = 1;
    step();
    @(negedge clk) check("post_abort_own_cond", 8'(RegWrite), 8'd0);
    RegW = 0;

    // Illegal headers.
    Cond = 4'b1110; PredStart = 1; InstrDone = 1; PredLen = 3'd0;
    step();
    @(negedge clk) begin
      check("len0_err", 8'(PredErr), 8'(ERR_EN));
      check("len0_active", 8'(PredActive), 8'd0);
    end
    PredLen = 3'd5;
    step();
    @(negedge clk) check("len5_active", 8'(PredActive), 8'd0);
    PredStart = 0; InstrDone = 0;

    // Reset in the middle of a block.
    Cond = 4'b1110; PredStart = 1; InstrDone = 1; PredLen = 3'd4; PredMask = '0;
    step();
    PredStart = 0; InstrDone = 0; RegW = 1; MemW = 1;
    step();
    check("pre_rst_active", 8'(PredActive), 8'd1);
    check("pre_rst_regwrite", 8'(RegWrite), 8'd1);
    #1 reset = 1'b0;
    #1 begin
      check("midrst_active", 8'(PredActive), 8'd0);
      check("midrst_flags", 8'(Flags), 8'd0);
      check("midrst_regwrite", 8'(RegWrite), 8'd0);
      check("midrst_memwrite", 8'(MemWrite), 8'd0);
    end
    step();
    reset = 1'b1;
    clear_in();
    step();

    // Random instruction stream.
    for (int n = 0; n < 1500; n++) begin
      int ncyc;
      bit hdr;
      logic [3:0] c;
      logic [BLKDEPTH-1:0] pm;
      logic [CNTW-1:0] pl;
      ncyc = $urandom_range(1, 3);
      c    = 4'($urandom);
      hdr  = ($urandom % 4) == 0;
      pm   = BLKDEPTH'($urandom);
      pl   = CNTW'($urandom_range(0, 7));
      for (int k = 0; k < ncyc; k++) begin
        Cond      = c;
        ALUFlags  = 4'($urandom);
        FlagW     = NGRP'($urandom);
        RegW      = 1'($urandom);
        MemW      = 1'($urandom);
        PCS       = ($urandom % 6) == 0;
        NextPC    = ($urandom % 5) == 0;
        InstrDone = (k == ncyc - 1);
        PredStart = hdr && (k == ncyc - 1);
        PredMask  = pm;
        PredLen   = pl;
        reset     = ($urandom % 300) != 0;
        step();
      end
    end
    reset = 1'b1;
    clear_in();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
